// File: rtl/coolgirl_config_regs.sv
// coolgirl_config_regs: shadow/live mapper config with atomic commit and sticky lock; readback when COOLGIRL_CFG_READBACK_EN is defined
module coolgirl_config_regs #(
  parameter logic [6:0] PRG_MASK_RESET = 7'h7E,
  parameter logic [4:0] CHR_MASK_RESET = 5'h1F
) (
  input  logic        m2,
  input  logic        reset,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_out_enabled,
  output logic [12:0] cpu_base,
  output logic [6:0]  prg_mask,
  output logic [4:0]  chr_mask,
  output logic [1:0]  sram_page,
  output logic        sram_enabled,
  output logic        four_screen,
  output logic        chr_write_enabled,
  output logic        prg_write_enabled,
  output logic        map_rom_on_6000,
  output logic [4:0]  mapper,
  output logic        cfg_locked,
  output logic        cfg_commit
);
  logic        hit, wr, commit;
  logic [2:0]  idx;
  logic [12:0] s_base;
  logic [6:0]  s_prg;
  logic [4:0]  s_chr, s_mapper;
  logic [1:0]  s_sram_page;
  logic        s_sram_en, dirty;
  logic [3:0]  s_flags;
  logic        unused;
  assign hit    = romsel && cpu_addr_in[14:12] == 3'b101;
  assign idx    = cpu_addr_in[2:0];
  assign wr     = hit && !cpu_rw_in && !cfg_locked;
  assign commit = wr && idx == 3'd7 && cpu_data_in[0];
  assign unused = ^{cpu_addr_in[11:3], dirty};
  // shadow file, dirty and lock tracking on the falling edge of m2
  always_ff @(negedge m2 or posedge reset)
    if (reset) begin
      s_base      <= '0;
      s_prg       <= PRG_MASK_RESET;
      s_chr       <= CHR_MASK_RESET;
      s_sram_page <= '0;
      s_sram_en   <= 1'b0;
      s_mapper    <= '0;
      s_flags     <= 4'b0010;
      dirty       <= 1'b0;
      cfg_locked  <= 1'b0;
    end else if (wr) begin
      case (idx)
        3'd0: s_base[12:8] <= cpu_data_in[4:0];
        3'd1: s_base[7:0]  <= cpu_data_in;
        3'd2: s_prg        <= cpu_data_in[6:0];
        3'd3: s_chr        <= cpu_data_in[4:0];
        3'd4: {s_sram_en, s_sram_page} <= {cpu_data_in[7], cpu_data_in[1:0]};
        3'd5: s_mapper     <= cpu_data_in[4:0];
        3'd6: s_flags      <= cpu_data_in[3:0];
        default: cfg_locked <= cpu_data_in[7];
      endcase
      dirty <= idx != 3'd7 ? 1'b1 : cpu_data_in[0] ? 1'b0 : dirty;
    end
  // live outputs only move on a commit, so they stay glitch-free in between
  always_ff @(negedge m2 or posedge reset)
    if (reset) begin
      cpu_base          <= '0;
      prg_mask          <= PRG_MASK_RESET;
      chr_mask          <= CHR_MASK_RESET;
      sram_page         <= '0;
      sram_enabled      <= 1'b0;
      mapper            <= '0;
      {map_rom_on_6000, prg_write_enabled, chr_write_enabled, four_screen} <= 4'b0010;
      cfg_commit        <= 1'b0;
    end else begin
      cfg_commit <= commit;
      if (commit) begin
        cpu_base     <= s_base;
        prg_mask     <= s_prg;
        chr_mask     <= s_chr;
        sram_page    <= s_sram_page;
        sram_enabled <= s_sram_en;
        mapper       <= s_mapper;
        {map_rom_on_6000, prg_write_enabled, chr_write_enabled, four_screen} <= s_flags;
      end
    end
`ifdef COOLGIRL_CFG_READBACK_EN
  // combinational readback of the shadow file and status during a read hit
  always_comb begin
    cpu_data_out_enabled = !reset && m2 && cpu_rw_in && hit;
    cpu_data_out = '0;
    if (cpu_data_out_enabled)
      case (idx)
        3'd0: cpu_data_out = {3'b0, s_base[12:8]};
        3'd1: cpu_data_out = s_base[7:0];
        3'd2: cpu_data_out = {1'b0, s_prg};
        3'd3: cpu_data_out = {3'b0, s_chr};
        3'd4: cpu_data_out = {s_sram_en, 5'b0, s_sram_page};
        3'd5: cpu_data_out = {3'b0, s_mapper};
        3'd6: cpu_data_out = {4'b0, s_flags};
        default: cpu_data_out = {cfg_locked, 6'b0, dirty};
      endcase
  end
`else
  assign cpu_data_out = '0;
  assign cpu_data_out_enabled = 1'b0;
`endif
endmodule

// File: tb/tb_coolgirl_config_regs.sv
// tb_coolgirl_config_regs: directed checks of staging, commit, mirroring, lock and async reset
module tb_coolgirl_config_regs;
  logic        m2 = 1'b0, reset = 1'b0, romsel = 1'b1, cpu_rw_in = 1'b1;
  logic [14:0] cpu_addr_in = '0;
  logic [7:0]  cpu_data_in = '0;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_out_enabled;
  logic [12:0] cpu_base;
  logic [6:0]  prg_mask;
  logic [4:0]  chr_mask, mapper;
  logic [1:0]  sram_page;
  logic        sram_enabled, four_screen, chr_write_enabled, prg_write_enabled, map_rom_on_6000;
  logic        cfg_locked, cfg_commit;
  int checks = 0, failures = 0;

  coolgirl_config_regs dut (
    .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
    .cpu_data_out(cpu_data_out), .cpu_data_out_enabled(cpu_data_out_enabled),
    .cpu_base(cpu_base), .prg_mask(prg_mask), .chr_mask(chr_mask),
    .sram_page(sram_page), .sram_enabled(sram_enabled), .four_screen(four_screen),
    .chr_write_enabled(chr_write_enabled), .prg_write_enabled(prg_write_enabled),
    .map_rom_on_6000(map_rom_on_6000), .mapper(mapper),
    .cfg_locked(cfg_locked), .cfg_commit(cfg_commit)
  );

  always #10 m2 = ~m2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d, input logic rs = 1'b1);
    @(posedge m2);
    cpu_addr_in = a; cpu_data_in = d; cpu_rw_in = 1'b0; romsel = rs;
    @(negedge m2); #1;
    cpu_addr_in = '0; cpu_rw_in = 1'b1; romsel = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [14:0] a, input logic [7:0] d);
    @(posedge m2);
    cpu_addr_in = a; cpu_rw_in = 1'b1; romsel = 1'b1;
    #2;
`ifdef COOLGIRL_CFG_READBACK_EN
    chk({tag, "_en"}, cpu_data_out_enabled, 1);
    chk(tag, cpu_data_out, d);
`else
    chk({tag, "_en"}, cpu_data_out_enabled, 0);
    chk(tag, cpu_data_out, 0 & d);
`endif
    @(negedge m2); #1;
    cpu_addr_in = '0;
  endtask

  task automatic idle;
    @(negedge m2); #1;
  endtask

  initial begin
    #2 reset = 1'b1;
    #20;
    chk("rst_base", cpu_base, 0);
    chk("rst_prg", prg_mask, 7'h7E);
    chk("rst_chr", chr_mask, 5'h1F);
    chk("rst_sram", {sram_enabled, sram_page}, 0);
    chk("rst_flags", {map_rom_on_6000, prg_write_enabled, chr_write_enabled, four_screen}, 4'b0010);
    chk("rst_mapper", mapper, 0);
    chk("rst_status", {cfg_locked, cfg_commit}, 0);
    chk("rst_rd", {cpu_data_out_enabled, cpu_data_out}, 0);
    #3 reset = 1'b0;

    wr(15'h5001, 8'h12);
    wr(15'h5002, 8'h70);
    wr(15'h5005, 8'h04);
    chk("stage_base", cpu_base, 0);
    chk("stage_prg", prg_mask, 7'h7E);
    chk("stage_mapper", mapper, 0);
    chk("stage_commit", cfg_commit, 0);
    rd("rd_dirty", 15'h5007, 8'h01);
    rd("rd_prg", 15'h5002, 8'h70);
    wr(15'h5007, 8'h01);
    chk("c1_base", cpu_base, 13'h012);
    chk("c1_prg", prg_mask, 7'h70);
    chk("c1_mapper", mapper, 5'd4);
    chk("c1_pulse", cfg_commit, 1);
    idle;
    chk("c1_pulse_end", cfg_commit, 0);
    rd("rd_clean", 15'h5007, 8'h00);

    wr(15'h5FFD, 8'hFF);
    chk("mirror_pending", mapper, 5'd4);
    wr(15'h5007, 8'h01);
    chk("mirror_mapper", mapper, 5'h1F);
    chk("mirror_prg", prg_mask, 7'h70);
    wr(15'h5005, 8'h03, 1'b0);
    wr(15'h4005, 8'h03);
    wr(15'h5007, 8'h01);
    chk("miss_mapper", mapper, 5'h1F);

    wr(15'h5000, 8'hFF);
    wr(15'h5004, 8'h83);
    wr(15'h5006, 8'hFF);
    wr(15'h5003, 8'h0A);
    rd("rd_5003", 15'h5003, 8'h0A);
    rd("rd_5004", 15'h5004, 8'h83);
    rd("rd_5006", 15'h5006, 8'h0F);
    rd("rd_5007", 15'h5007, 8'h01);
    chk("pend_chr", chr_mask, 5'h1F);
    wr(15'h5007, 8'h01);
    chk("c2_base", cpu_base, 13'h1F12);
    chk("c2_chr", chr_mask, 5'h0A);
    chk("c2_sram", {sram_enabled, sram_page}, 3'b111);
    chk("c2_flags", {map_rom_on_6000, prg_write_enabled, chr_write_enabled, four_screen}, 4'b1111);
    wr(15'h5007, 8'h01);
    chk("b2b_pulse", cfg_commit, 1);
    idle;
    chk("b2b_end", cfg_commit, 0);

    wr(15'h5002, 8'h15);
    wr(15'h5007, 8'h81);
    chk("lock_prg", prg_mask, 7'h15);
    chk("lock_set", cfg_locked, 1);
    chk("lock_pulse", cfg_commit, 1);
    wr(15'h5005, 8'h02);
    wr(15'h5007, 8'h01);
    chk("locked_mapper", mapper, 5'h1F);
    chk("locked_pulse", cfg_commit, 0);
    chk("locked_still", cfg_locked, 1);
    rd("rd_locked", 15'h5005, 8'h1F);
    rd("rd_lock", 15'h5007, 8'h80);

    @(posedge m2); #5 reset = 1'b1;
    #1;
    chk("arst_prg", prg_mask, 7'h7E);
    chk("arst_base", cpu_base, 0);
    chk("arst_mapper", mapper, 0);
    chk("arst_flags", {map_rom_on_6000, prg_write_enabled, chr_write_enabled, four_screen}, 4'b0010);
    chk("arst_status", {cfg_locked, cfg_commit}, 0);
    #2 reset = 1'b0;
    wr(15'h5005, 8'h06);
    wr(15'h5007, 8'h01);
    chk("post_rst_mapper", mapper, 5'd6);

    wr(15'h5005, 8'h09);
    wr(15'h5007, 8'h80);
    chk("lockonly_set", cfg_locked, 1);
    chk("lockonly_mapper", mapper, 5'd6);
    chk("lockonly_pulse", cfg_commit, 0);
    wr(15'h5007, 8'h01);
    chk("lockonly_after", mapper, 5'd6);
    rd("rd_lockonly", 15'h5007, 8'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coolgirl_config_regs.md
# coolgirl_config_regs

Loader-facing configuration controller for the multicart top level. Decodes CPU writes to $5000-$5007 into a shadow register file and applies all fields atomically to the live mapping outputs on a commit write. Live outputs drive flash/SRAM/PPU address composition and mapper selection. A sticky lock bit freezes the configuration until reset, so the launched game cannot disturb it.

## Interface

Parameters:
- PRG_MASK_RESET, 7'h7E: reset value of prg_mask; a 32 KB menu window at flash base 0.
- CHR_MASK_RESET, 5'h1F: reset value of chr_mask; a single 8 KB CHR window.

Ports:
- m2  in  1  CPU M2; the only clock; all state updates on its falling edge.
- reset  in  1  asynchronous, active-high reset.
- romsel  in  1  /ROMSEL; must be high (not $8000-$FFFF) for a register hit.
- cpu_rw_in  in  1  1 = read, 0 = write.
- cpu_addr_in  in  15  CPU A14..A0.
- cpu_data_in  in  8  CPU data bus, input side.
- cpu_data_out  out  8  readback data.
- cpu_data_out_enabled  out  1  drive enable for readback.
- cpu_base  out  13  live flash base, bits [26:14].
- prg_mask  out  7  live PRG mask, bits [20:14].
- chr_mask  out  5  live CHR mask, bits [17:13].
- sram_page  out  2  live SRAM page.
- sram_enabled, four_screen, chr_write_enabled, prg_write_enabled, map_rom_on_6000  out  1 each  live flags.
- mapper  out  5  live mapper select.
- cfg_locked  out  1  lock state.
- cfg_commit  out  1  one-cycle pulse when live outputs were just updated.

## Operation

- Register hit: romsel=1, cpu_addr_in[14:12]=3'b101, index = cpu_addr_in[2:0]. Bits [11:3] are don't-care, so the registers mirror through $5000-$5FFF.
- Shadow writes, taken only when cfg_locked=0:
  - $5000: base[26:22] = D[4:0].
  - $5001: base[21:14] = D[7:0].
  - $5002: prg_mask = D[6:0].
  - $5003: chr_mask = D[4:0].
  - $5004: sram_page = D[1:0], sram_enabled = D[7].
  - $5005: mapper = D[4:0].
  - $5006: four_screen D[0], chr_write_enabled D[1], prg_write_enabled D[2], map_rom_on_6000 D[3].
- Unused data bits are ignored.
- Any shadow write to $5000-$5006 sets the dirty bit.
- $5007 control write, taken only when unlocked:
  - D[0]=1 (commit): copy all shadow fields to the live outputs, clear dirty, pulse cfg_commit.
  - D[7]=1 (lock): set cfg_locked.
  - Both bits set: commit happens on that edge and lock takes effect on the same edge.
  - D[7]=1 with D[0]=0: lock without applying; pending shadow contents never reach the live outputs.
- Locked state: every write is ignored, shadow included. Only reset clears the lock.
- Reset values:
  - Shadow and live fields: base 0, prg_mask = PRG_MASK_RESET, chr_mask = CHR_MASK_RESET, sram_page 0, mapper 0.
  - Flags: chr_write_enabled=1, all other flags 0.
  - Status: dirty=0, cfg_locked=0, cfg_commit=0.
  - Readback: cpu_data_out=0, cpu_data_out_enabled=0.

## Timing

- Writes are sampled on the falling edge of m2 with cpu_rw_in=0 and a register hit.
- A shadow write is readable (with readback compiled in) from the next m2 high phase.
- Commit latency: live outputs change at the same falling edge that samples the $5007 write. Zero added cycles.
- cfg_commit is high from that falling edge until the next falling edge: exactly one m2 period.
- Back-to-back commits on consecutive cycles give cfg_commit high for two consecutive periods.
- Asynchronous reset asserted mid-operation immediately forces every reset value, including the live outputs and cfg_commit. The first write is accepted at the first falling edge after reset deasserts.
- Live outputs are registered; they never glitch between commits.

## Configuration

- Macro: COOLGIRL_CFG_READBACK_EN.
- Defined: during a read hit (m2=1, cpu_rw_in=1, romsel=1) cpu_data_out_enabled=1, combinationally.
  - $5000-$5006 return the shadow fields in their write bit positions, with unused bits 0.
  - $5007 returns {cfg_locked, 6'b0, dirty}.
  - Reads have no side effects.
- Undefined: cpu_data_out and cpu_data_out_enabled are tied to 0. There is no readback logic.

## Test plan

- Reset check: assert reset, release, sample all outputs -> prg_mask=7'h7E, chr_mask=5'h1F, chr_write_enabled=1, everything else 0.
- Staged then committed: write $5001=8'h12, $5002=8'h70, $5005=8'h04 -> live outputs unchanged; write $5007=8'h01 -> cpu_base=13'h012, prg_mask=7'h70, mapper=4, cfg_commit high for exactly one m2 period.
- Mirror and ignored bits: write $5FFD=8'hFF (index 5) -> after commit, mapper=5'h1F. Write with romsel=0 or cpu_addr_in[14:12]=3'b100 -> no change.
- Combined commit and lock: write $5007=8'h81, then $5005=8'h02 and $5007=8'h01 -> first commit applied, cfg_locked=1, later writes ignored, no further cfg_commit.
- Reset while locked: assert reset asynchronously between m2 edges -> outputs return to reset values immediately, lock cleared, next write accepted.
- With COOLGIRL_CFG_READBACK_EN: write $5003=8'h0A -> read $5007 returns 8'h01, read $5003 returns 8'h0A. After commit, $5007 reads 8'h00. Without the macro, cpu_data_out_enabled stays 0 throughout.
